// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Cycles from the accepting edge to the edge that raises done.
  function automatic int seq_mul_latency(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/seq_multiplier_cond_negate.sv
// Two's-complement conditional negation: result = neg ? -value : value.
module cond_negate #(
  parameter int N = 8
) (
  input  logic         neg,
  input  logic [N-1:0] value,
  output logic [N-1:0] result
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  assign result = neg ? (~value + ONE) : value;

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier, signed or unsigned, fixed latency WIDTH+1
// from the accepting edge, with a start/done/busy handshake.
import seq_mul_pkg::*;

module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic [2*WIDTH-1:0] product,
  output logic               done,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e             state_r, state_nxt_s;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]   mplr_r;
  logic [WIDTH-1:0]   mcand_r;
  logic               neg_r;
  logic [2*WIDTH-1:0] product_r;
  logic               done_r;
  logic               busy_r;

  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] res_s;

  cond_negate #(.N(WIDTH)) u_neg_a (
    .neg    (signed_mode & multiplier[WIDTH-1]),
    .value  (multiplier),
    .result (a_mag_s)
  );

  cond_negate #(.N(WIDTH)) u_neg_b (
    .neg    (signed_mode & multiplicand[WIDTH-1]),
    .value  (multiplicand),
    .result (b_mag_s)
  );

  cond_negate #(.N(2*WIDTH)) u_neg_res (
    .neg    (neg_r),
    .value  ({acc_r, mplr_r}),
    .result (res_s)
  );

  // The extra MSB of the sum is the carry that shifts back into the accumulator.
  assign sum_s = {1'b0, acc_r} + (mplr_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = RUN;
        else       state_nxt_s = IDLE;
      end
      RUN: begin
        if (cnt_r == LAST_CNT) state_nxt_s = FINISH;
        else                   state_nxt_s = RUN;
      end
      FINISH:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r     <= {CW{1'b0}};
      acc_r     <= {WIDTH{1'b0}};
      mplr_r    <= {WIDTH{1'b0}};
      mcand_r   <= {WIDTH{1'b0}};
      neg_r     <= 1'b0;
      product_r <= {(2*WIDTH){1'b0}};
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            mplr_r  <= a_mag_s;
            mcand_r <= b_mag_s;
            neg_r   <= signed_mode & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
            acc_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        RUN: begin
          acc_r  <= sum_s[WIDTH:1];
          mplr_r <= {sum_s[0], mplr_r[WIDTH-1:1]};
          cnt_r  <= cnt_r + CNT_ONE;
        end
        FINISH: begin
          product_r <= res_s;
          done_r    <= 1'b1;
          busy_r    <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign product = product_r;
  assign done    = done_r;
  assign busy    = busy_r;

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised multi-cycle shift-add multiplier with start/done handshake. It supports selectable signed (two's complement) or unsigned operation and has a fixed, mode-independent latency. It succeeds the fixed 8-bit unsigned sequential multiplier in the ALU datapath and is driven by the ALU control FSM through the same start/done protocol.

## Interface
- `WIDTH`, default 8: operand width in bits, legal range 2..32; product is 2*WIDTH bits.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only in IDLE.
- `signed_mode` input 1: 1 = two's-complement operands; 0 = unsigned. Latched with operands.
- `multiplier` input WIDTH: operand A, latched on the accepting edge.
- `multiplicand` input WIDTH: operand B, latched on the accepting edge.
- `product` output 2*WIDTH: result register; holds the last result until the next completion.
- `done` output 1: one-cycle pulse; product is valid from this cycle onward.
- `busy` output 1: high while an operation is in flight.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: performs WIDTH iterations.
  - FINISH: applies sign fix and writes the result.
- IDLE → RUN when `start`=1 on a clock edge. On that edge:
  - latch `signed_mode`;
  - load magnitude registers: |A| and |B| in signed mode, raw values in unsigned mode;
  - latch the result sign, neg = A[MSB]^B[MSB] in signed mode, else 0;
  - clear the accumulator and the iteration counter.
- RUN, per edge:
  - if the multiplier-magnitude LSB is 1, add the multiplicand magnitude into the upper accumulator half;
  - shift the {carry, accumulator, multiplier} chain right by 1;
  - increment the counter.
  - After the WIDTH-th iteration → FINISH.
- FINISH, one edge:
  - product ← neg ? −acc : acc (2*WIDTH-bit two's complement);
  - done ← 1, busy ← 0;
  - → IDLE.
- Magnitude rules:
  - |−2^(WIDTH−1)| = 2^(WIDTH−1) is held as an unsigned WIDTH-bit value; no overflow.
  - The signed product always fits in 2*WIDTH bits.
  - The unsigned max (2^WIDTH−1)² fits exactly.
- `start` while busy (RUN/FINISH) is ignored; input changes during RUN have no effect.
- Zero operands run the full latency; there is no early termination.
- The result is −0 = 0; the negation of zero yields 0.

## Timing
- Reset values (asynchronous, immediate on `rst`=0): state IDLE, `product`=0, `done`=0, `busy`=0, counter and accumulators 0.
- Reset mid-operation aborts the operation. No `done` is produced, and `product` reads 0 after reset.
- Latency, counting the accepting edge as E0:
  - iterations occur on edges E1..E_WIDTH;
  - `product` and `done` update on edge E(WIDTH+1);
  - `done` is high for exactly the cycle after E(WIDTH+1).
- `busy` is high from E0 up to E(WIDTH+1), and low in the `done` cycle.
- Back-to-back operation: `start` held high in the `done` cycle is accepted (state is IDLE). Issue interval is WIDTH+2 cycles.
- `done` never asserts for two consecutive cycles.

## Structure
- Package `seq_mul_pkg`:
  - state typedef (IDLE/RUN/FINISH);
  - function `seq_mul_latency(width)` returning width+1, used by benches and the ALU controller.
- Counter width is $clog2(WIDTH+1), derived locally.
- Sub-module `cond_negate`:
  - parameter N;
  - inputs `neg` and `value[N-1:0]`;
  - output: two's-complement conditional negation.
  - Instanced twice at WIDTH for operand magnitudes, and once at 2*WIDTH for the result.

## Test plan
- WIDTH=8, unsigned, 255×255 → `product`=0xFE01 (65025); `done` exactly 9 edges after the accepting edge; `busy` high for 9 cycles.
- WIDTH=8, signed:
  - −128×−128 → 0x4000;
  - 85×−86 → 0xE372 (−7310);
  - −1×1 → 0xFFFF;
  - 0×−1 → 0x0000.
- WIDTH=8: pulse `start` at E3 of an operation with different operands → ignored; the original result is returned and only one `done` pulse occurs.
- WIDTH=8: assert `rst` low at E4 of 123×45 → all outputs 0 immediately; no `done`. A subsequent 123×45 returns 5535 (0x159F).
- WIDTH=8, back-to-back: hold `start` high through `done`. Expect 170×85=14450 (0x3872), then 128×128=16384, with `done` pulses 10 cycles apart.
- WIDTH=16, unsigned, 0xFFFF×0xFFFF → 0xFFFE0001 at latency 17. WIDTH=16, signed, 0x8000×0x7FFF → 0xC0008000.
